multi_edge_detector: RTL and testbench

Parametrised, multi-channel successor to the single-bit level-to-pulse edge detector. Each channel synchronises an asynchronous level input and debounces it. It then emits a one-cycle tick on rising, falling or both edges, selected per channel, and keeps a sticky pending flag that software clears. The block sits between external/push-button inputs and the control logic and interrupt aggregation.

---
 rtl/multi_edge_detector.sv | 69 ++++++
 tb/tb_multi_edge_detector.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// Multi-channel level-to-pulse edge detector: per-channel synchroniser, debounce
// filter, mode-selected edge tick and a software-cleared sticky pending flag.
module multi_edge_detector #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   lvl,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   edge_tick,
  output logic [N_CH-1:0]   level_out,
  output logic [N_CH-1:0]   pending,
  output logic              irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [N_CH-1:0][SYNC_STAGES-1:0] sync_chain;
  logic [N_CH-1:0][CW-1:0]          cnt;
  logic [N_CH-1:0]                  sync_last;
  logic [N_CH-1:0]                  differ;
  logic [N_CH-1:0]                  accept;
  logic [N_CH-1:0]                  tick_next;

  // accept marks the edge at which a channel's debounced level flips
  always_comb begin
    sync_last = '0;
    differ    = '0;
    accept    = '0;
    tick_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      sync_last[i] = sync_chain[i][SYNC_STAGES-1];
      differ[i]    = sync_last[i] != level_out[i];
      accept[i]    = differ[i] && (cnt[i] == CNT_LAST);
      tick_next[i] = accept[i] &
                     ((sync_last[i] & mode[2*i]) | (~sync_last[i] & mode[2*i+1]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain <= '0;
      cnt        <= '0;
      level_out  <= '0;
      edge_tick  <= '0;
      pending    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        sync_chain[i] <= {sync_chain[i][SYNC_STAGES-2:0], lvl[i]};
        if (!differ[i] || accept[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + CNT_ONE;
      end
      level_out <= (level_out & ~accept) | (sync_last & accept);
      edge_tick <= tick_next;
      // a new edge outranks a same-cycle clear
      pending   <= tick_next | (pending & ~clr);
    end
  end

  assign irq = |pending;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: scoreboard against a sample-history reference
// model, directed scenarios, plus a small-parameter instance for latency checks.
module tb_multi_edge_detector;

  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] lvl, clr;
  logic [2*N-1:0] mode;
  logic [N-1:0] edge_tick, level_out, pending;
  logic         irq;

  logic [0:0] lvl_b, clr_b, tick_b, lo_b, pend_b;
  logic [1:0] mode_b;
  logic       irq_b;

  int checks = 0;
  int errors = 0;
  int tick_cnt [N];

  always #5 clk = ~clk;

  multi_edge_detector #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .lvl(lvl), .mode(mode), .clr(clr),
    .edge_tick(edge_tick), .level_out(level_out), .pending(pending), .irq(irq));

  multi_edge_detector #(.N_CH(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .lvl(lvl_b), .mode(mode_b), .clr(clr_b),
    .edge_tick(tick_b), .level_out(lo_b), .pending(pend_b), .irq(irq_b));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once D consecutive synchronised
  // samples (the raw input seen S edges earlier) disagree with it.
  typedef struct packed {
    logic [N-1:0] tick;
    logic [N-1:0] lvl;
    logic [N-1:0] pend;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] hist_q[$];
  logic [N-1:0] m_lvl, m_pend, m_samp, m_tick;
  int           run [N];
  exp_t         e_push, e_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q.delete();
      exp_q.delete();
      m_lvl  = '0;
      m_pend = '0;
      for (int c = 0; c < N; c++) run[c] = 0;
    end else begin
      m_samp = (hist_q.size() >= S) ? hist_q[hist_q.size()-S] : '0;
      hist_q.push_back(lvl);
      if (hist_q.size() > S) void'(hist_q.pop_front());
      m_tick = '0;
      for (int c = 0; c < N; c++) begin
        if (m_samp[c] != m_lvl[c]) begin
          run[c]++;
          if (run[c] == D) begin
            m_lvl[c]  = m_samp[c];
            run[c]    = 0;
            m_tick[c] = m_samp[c] ? mode[2*c] : mode[2*c+1];
          end
        end else begin
          run[c] = 0;
        end
      end
      m_pend = m_tick | (m_pend & ~clr);
      e_push.tick = m_tick;
      e_push.lvl  = m_lvl;
      e_push.pend = m_pend;
      exp_q.push_back(e_push);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {19'd0, edge_tick, level_out, pending, irq}, 32'd0);
    end else if (exp_q.size() > 0) begin
      e_pop = exp_q.pop_front();
      chk("sb_tick",    32'(edge_tick), 32'(e_pop.tick));
      chk("sb_level",   32'(level_out), 32'(e_pop.lvl));
      chk("sb_pending", 32'(pending),   32'(e_pop.pend));
      chk("sb_irq",     32'(irq),       32'(|e_pop.pend));
      for (int c = 0; c < N; c++) if (edge_tick[c]) tick_cnt[c]++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Counts edges until the selected channel's level_out equals want (bounded).
  task automatic measure(input int which, input int ch, input logic want,
                         output int lat, output logic tick_at, output int ticks);
    logic t, l;
    lat = -1; tick_at = 1'b0; ticks = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      t = (which == 0) ? edge_tick[ch] : tick_b[0];
      l = (which == 0) ? level_out[ch] : lo_b[0];
      if (t) ticks++;
      if (l == want) begin
        lat = k;
        tick_at = t;
        break;
      end
    end
    #1;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N; c++) tick_cnt[c] = 0;
  endtask

  int   lat, ticks;
  logic tick_at;
  logic [N-1:0] seen;

  initial begin
    rst = 1'b1; lvl = '0; clr = '0; mode = 8'h55;
    lvl_b = 1'b0; clr_b = 1'b0; mode_b = 2'b11;
    clear_counts();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    step(2);

    // rising edge on channel 0, mode 01
    lvl[0] = 1'b1;
    measure(0, 0, 1'b1, lat, tick_at, ticks);
    chk("rise_latency", 32'(lat), 32'd6);
    chk("rise_tick_at_update", 32'(tick_at), 32'd1);
    @(posedge clk); #1;
    chk("rise_tick_one_cycle", 32'(edge_tick[0]), 32'd0);
    chk("rise_pending", 32'(pending[0]), 32'd1);
    chk("rise_irq", 32'(irq), 32'd1);
    #1;
    lvl[0] = 1'b0;
    measure(0, 0, 1'b0, lat, tick_at, ticks);
    chk("fall_latency", 32'(lat), 32'd6);
    chk("fall_no_tick", 32'(ticks), 32'd0);

    // glitch rejection on channel 1, mode 11
    mode = 8'b01_01_11_01; clr = 4'hF; step(1); clr = '0;
    clear_counts();
    lvl[1] = 1'b1; step(3); lvl[1] = 1'b0; step(12);
    chk("glitch_level", 32'(level_out[1]), 32'd0);
    chk("glitch_ticks", 32'(tick_cnt[1]), 32'd0);
    chk("glitch_pending", 32'(pending[1]), 32'd0);
    lvl[1] = 1'b1; step(4); lvl[1] = 1'b0; step(14);
    chk("pulse4_ticks", 32'(tick_cnt[1]), 32'd2);
    chk("pulse4_pending", 32'(pending[1]), 32'd1);

    // per-channel modes 00/01/10/11
    mode = 8'b11_10_01_00; clr = 4'hF; step(1); clr = '0;
    clear_counts();
    lvl = 4'hF; step(10); lvl = 4'h0; step(12);
    chk("mode00_ticks", 32'(tick_cnt[0]), 32'd0);
    chk("mode01_ticks", 32'(tick_cnt[1]), 32'd1);
    chk("mode10_ticks", 32'(tick_cnt[2]), 32'd1);
    chk("mode11_ticks", 32'(tick_cnt[3]), 32'd2);
    chk("mode_pending", 32'(pending), 32'hE);

    // clear, then clear colliding with a new set
    clr = 4'b1010; step(1); clr = '0;
    chk("clr_partial", 32'(pending), 32'h4);
    chk("clr_partial_irq", 32'(irq), 32'd1);
    clr = 4'b0100; step(1); clr = '0;
    chk("clr_all", 32'(pending), 32'h0);
    chk("clr_irq_low", 32'(irq), 32'd0);
    mode = 8'h55;
    lvl[2] = 1'b1; step(5);
    clr[2] = 1'b1;
    @(posedge clk); #1;
    chk("setclr_tick", 32'(edge_tick[2]), 32'd1);
    chk("setclr_pending", 32'(pending[2]), 32'd1);
    #1 clr = '0;

    // reset mid-debounce, lvl held high through release
    lvl = 4'hF; step(4);
    rst = 1'b1; #1;
    chk("async_reset_outputs", {28'd0, edge_tick | level_out | pending}, 32'd0);
    chk("async_reset_irq", 32'(irq), 32'd0);
    step(2);
    rst = 1'b0;
    lat = -1; seen = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (edge_tick != '0) begin
        lat = k;
        seen = edge_tick;
        break;
      end
    end
    #1;
    chk("powerup_latency", 32'(lat), 32'd6);
    chk("powerup_all_tick", 32'(seen), 32'hF);

    // small-parameter instance: SYNC_STAGES 3, DEBOUNCE_CYCLES 1
    lvl_b = 1'b1;
    measure(1, 0, 1'b1, lat, tick_at, ticks);
    chk("b_rise_latency", 32'(lat), 32'd4);
    chk("b_rise_tick", 32'(tick_at), 32'd1);
    @(posedge clk); #1;
    chk("b_tick_one_cycle", 32'(tick_b), 32'd0);
    chk("b_pending", 32'(pend_b), 32'd1);
    chk("b_irq", 32'(irq_b), 32'd1);
    #1;
    clr_b = 1'b1; step(1); clr_b = 1'b0;
    chk("b_clr", 32'(pend_b), 32'd0);
    chk("b_clr_irq", 32'(irq_b), 32'd0);
    clr_b = 1'b1; lvl_b = 1'b0;
    measure(1, 0, 1'b0, lat, tick_at, ticks);
    chk("b_fall_latency", 32'(lat), 32'd4);
    chk("b_fall_tick", 32'(tick_at), 32'd1);
    chk("b_setclr_pending", 32'(pend_b), 32'd1);
    clr_b = 1'b0;

    // randomized traffic checked by the scoreboard
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 4) == 0) lvl[c] = ~lvl[c];
        clr[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 3) == 0) lvl_b = ~lvl_b;
      clr_b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b1;
        #3 rst = 1'b0;
      end
      step(1);
    end
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
